// File: rtl/slave_switch_pkg.sv
// rtl/slave_switch_pkg.sv - shared types and helpers for the per-master W steering block.
// The FIFO entry carries awlen only when SLAVE_WSTEER_LEN_CHK_EN is defined.
package slave_switch_pkg;

  localparam int TGT_FIELD_W = 8;
  localparam int LEN_FIELD_W = 8;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  typedef struct packed {
`ifdef SLAVE_WSTEER_LEN_CHK_EN
    logic [LEN_FIELD_W-1:0] len;
`endif
    logic [TGT_FIELD_W-1:0] tgt;
  } wfifo_entry_t;

  // One extra bit so a full FIFO (count == DEPTH) is representable.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int unsigned clamp_tgt(input int unsigned raw, input int unsigned m);
    return (raw >= m) ? (m - 1) : raw;
  endfunction

endpackage

// File: rtl/wsteer_rr_arb.sv
// rtl/wsteer_rr_arb.sv - per-slave round-robin W arbiter that holds its grant for a whole burst.
module wsteer_rr_arb
  import slave_switch_pkg::*;
#(
  parameter int N     = 2,
  parameter int LOG_N = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_i,
  input  logic             beat_hs_i,
  input  logic             beat_last_i,
  output logic             gnt_valid_o,
  output logic [LOG_N-1:0] gnt_idx_o
);

  arb_state_e       state_q, state_d;
  logic [LOG_N-1:0] lock_q, lock_d;
  logic [LOG_N-1:0] rr_q, rr_d;
  logic [LOG_N-1:0] pick;
  logic             found;

  // Two-pass scan: first from rr_q upward, then wrap around to the low indices.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[i] && (i >= int'(rr_q))) begin
        found = 1'b1;
        pick  = LOG_N'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[i]) begin
        found = 1'b1;
        pick  = LOG_N'(i);
      end
    end
    gnt_valid_o = found;
    gnt_idx_o   = pick;
    if (state_q == ARB_LOCK) begin
      gnt_valid_o = 1'b1;
      gnt_idx_o   = lock_q;
    end
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    rr_d    = rr_q;
    if (beat_hs_i) begin
      if (beat_last_i) begin
        state_d = ARB_IDLE;
        rr_d    = (int'(gnt_idx_o) >= N - 1) ? '0 : gnt_idx_o + LOG_N'(1);
      end else if (state_q == ARB_IDLE) begin
        state_d = ARB_LOCK;
        lock_d  = gnt_idx_o;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      lock_q  <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      rr_q    <= rr_d;
    end
  end

endmodule

// File: rtl/slave_write_steer.sv
// rtl/slave_write_steer.sv - steers each master's W bursts to the slave recorded at its AW handshake.
// Define SLAVE_WSTEER_LEN_CHK_EN to generate wlast from awlen and flag length mismatches on err_o.
module slave_write_steer
  import slave_switch_pkg::*;
#(
  parameter int N          = 2,
  parameter int M          = 2,
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int LOG_N      = (N > 1) ? $clog2(N) : 1,
  parameter int LOG_M      = (M > 1) ? $clog2(M) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N-1:0]                      s_awvalid,
  output logic [N-1:0]                      s_awready,
  input  logic [N-1:0][ADDR_WIDTH-1:0]      s_awaddr,
  input  logic [N-1:0][7:0]                 s_awlen,
  output logic [N-1:0]                      m_awvalid,
  input  logic [N-1:0]                      m_awready,
  input  logic [N-1:0]                      s_wvalid,
  output logic [N-1:0]                      s_wready,
  input  logic [N-1:0][WIDTH-1:0]           s_wdata,
  input  logic [N-1:0][WIDTH/8-1:0]         s_wstrb,
  input  logic [N-1:0]                      s_wlast,
  output logic [M-1:0]                      m_wvalid,
  input  logic [M-1:0]                      m_wready,
  output logic [M-1:0][WIDTH-1:0]           m_wdata,
  output logic [M-1:0][WIDTH/8-1:0]         m_wstrb,
  output logic [M-1:0]                      m_wlast,
  output logic [M-1:0][LOG_N-1:0]           m_wsrc
`ifdef SLAVE_WSTEER_LEN_CHK_EN
  ,
  output logic [N-1:0]                      err_o
`endif
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = fifo_cnt_w(DEPTH);
  localparam int STRB_W = WIDTH / 8;

  logic [N-1:0]                   full;
  logic [N-1:0]                   empty;
  logic [N-1:0]                   push;
  logic [N-1:0]                   pop;
  logic [N-1:0]                   w_hs;
  logic [N-1:0]                   w_last;
  logic [N-1:0][TGT_FIELD_W-1:0]  head_tgt;
  logic [M-1:0][N-1:0]            req;
  logic [M-1:0]                   gnt_valid;
  logic [M-1:0][LOG_N-1:0]        gnt_idx;
  logic                           unused_bits;

  // Only the top LOG_M address bits select the slave.
  assign unused_bits = ^{s_awaddr, s_awlen};

  always_comb begin
    req = '0;
    for (int j = 0; j < M; j++) begin
      for (int i = 0; i < N; i++) begin
        req[j][i] = s_wvalid[i] & ~empty[i] & (int'(head_tgt[i]) == j);
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_master
    wfifo_entry_t     mem_q [DEPTH];
    wfifo_entry_t     entry_in;
    wfifo_entry_t     head_entry;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wready_l;

    assign full[i]      = (cnt_q == CNT_W'(DEPTH));
    assign empty[i]     = (cnt_q == '0);
    assign m_awvalid[i] = s_awvalid[i] & ~full[i];
    assign s_awready[i] = m_awready[i] & ~full[i];
    assign push[i]      = s_awvalid[i] & s_awready[i];
    assign pop[i]       = w_hs[i] & w_last[i];
    assign head_entry   = mem_q[rptr_q];
    assign head_tgt[i]  = head_entry.tgt;

    always_comb begin
      entry_in     = '0;
      entry_in.tgt = TGT_FIELD_W'(clamp_tgt(int'(s_awaddr[i][ADDR_WIDTH-1 -: LOG_M]), M));
`ifdef SLAVE_WSTEER_LEN_CHK_EN
      entry_in.len = s_awlen[i];
`endif
    end

    always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (push[i]) wptr_d = wptr_q + PTR_W'(1);
      if (pop[i])  rptr_d = rptr_q + PTR_W'(1);
      if (push[i] && !pop[i])      cnt_d = cnt_q + CNT_W'(1);
      else if (!push[i] && pop[i]) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
        for (int d = 0; d < DEPTH; d++) mem_q[d] <= '0;
      end else begin
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
        cnt_q  <= cnt_d;
        if (push[i]) mem_q[wptr_q] <= entry_in;
      end
    end

    // Ready only from the slave this master's head entry points at, and only while granted there.
    always_comb begin
      wready_l = 1'b0;
      for (int j = 0; j < M; j++) begin
        if (int'(head_tgt[i]) == j) begin
          wready_l = m_wready[j] & gnt_valid[j] & (int'(gnt_idx[j]) == i);
        end
      end
    end
    assign s_wready[i] = wready_l & ~empty[i];
    assign w_hs[i]     = s_wvalid[i] & s_wready[i];

`ifdef SLAVE_WSTEER_LEN_CHK_EN
    logic [LEN_FIELD_W-1:0] beat_q, beat_d;

    assign w_last[i] = (beat_q == head_entry.len);
    assign err_o[i]  = w_hs[i] & (s_wlast[i] != w_last[i]);

    always_comb begin
      beat_d = beat_q;
      if (w_hs[i]) beat_d = w_last[i] ? '0 : beat_q + LEN_FIELD_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) beat_q <= '0;
      else     beat_q <= beat_d;
    end
`else
    assign w_last[i] = s_wlast[i];
`endif
  end

  for (genvar j = 0; j < M; j++) begin : g_slave
    logic              vld_l;
    logic [WIDTH-1:0]  data_l;
    logic [STRB_W-1:0] strb_l;
    logic              last_l;

    wsteer_rr_arb #(
      .N     (N),
      .LOG_N (LOG_N)
    ) u_arb (
      .clk         (clk),
      .rst         (rst),
      .req_i       (req[j]),
      .beat_hs_i   (m_wvalid[j] & m_wready[j]),
      .beat_last_i (m_wlast[j]),
      .gnt_valid_o (gnt_valid[j]),
      .gnt_idx_o   (gnt_idx[j])
    );

    always_comb begin
      vld_l  = 1'b0;
      data_l = '0;
      strb_l = '0;
      last_l = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (gnt_valid[j] && (int'(gnt_idx[j]) == i)) begin
          vld_l  = req[j][i];
          data_l = s_wdata[i];
          strb_l = s_wstrb[i];
          last_l = w_last[i];
        end
      end
    end

    assign m_wvalid[j] = vld_l;
    assign m_wdata[j]  = data_l;
    assign m_wstrb[j]  = strb_l;
    assign m_wlast[j]  = last_l;
    assign m_wsrc[j]   = gnt_valid[j] ? gnt_idx[j] : '0;
  end

endmodule

// File: tb/tb_slave_write_steer.sv
// tb/tb_slave_write_steer.sv - queue-based reference model plus directed and random stimulus.
module tb_slave_write_steer;

  localparam int N  = 2;
  localparam int M  = 2;
  localparam int W  = 32;
  localparam int AW = 32;
  localparam int D  = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N-1:0]           s_awvalid = '0;
  logic [N-1:0]           s_awready;
  logic [N-1:0][AW-1:0]   s_awaddr = '0;
  logic [N-1:0][7:0]      s_awlen = '0;
  logic [N-1:0]           m_awvalid;
  logic [N-1:0]           m_awready = '1;
  logic [N-1:0]           s_wvalid = '0;
  logic [N-1:0]           s_wready;
  logic [N-1:0][W-1:0]    s_wdata = '0;
  logic [N-1:0][W/8-1:0]  s_wstrb = '0;
  logic [N-1:0]           s_wlast = '0;
  logic [M-1:0]           m_wvalid;
  logic [M-1:0]           m_wready = '1;
  logic [M-1:0][W-1:0]    m_wdata;
  logic [M-1:0][W/8-1:0]  m_wstrb;
  logic [M-1:0]           m_wlast;
  logic [M-1:0][0:0]      m_wsrc;

  always #5 clk = ~clk;

  slave_write_steer #(
    .N(N), .M(M), .WIDTH(W), .ADDR_WIDTH(AW), .DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wlast(s_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wlast(m_wlast), .m_wsrc(m_wsrc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: per-master queue of recorded targets, per-slave burst owner and rr pointer.
  int qd [N][16];
  int qn [N];
  int owner [M];
  int rr [M];
  int g [M];
  logic [N-1:0] e_awvalid, e_awready, e_swready;
  logic [M-1:0] e_mwvalid;

  task automatic model_reset();
    for (int i = 0; i < N; i++) qn[i] = 0;
    for (int j = 0; j < M; j++) begin
      owner[j] = -1;
      rr[j]    = 0;
    end
  endtask

  function automatic int model_tgt(input logic [AW-1:0] a);
    int t;
    t = int'(a[AW-1]);
    return (t >= M) ? M - 1 : t;
  endfunction

  initial model_reset();

  always @(negedge clk) begin
    if (rst) model_reset();
    for (int i = 0; i < N; i++) begin
      e_awvalid[i] = s_awvalid[i] && (qn[i] < D);
      e_awready[i] = m_awready[i] && (qn[i] < D);
    end
    for (int j = 0; j < M; j++) begin
      g[j] = owner[j];
      if (g[j] < 0) begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (rr[j] + k) % N;
          if (g[j] < 0 && s_wvalid[c] && qn[c] > 0 && qd[c][0] == j) g[j] = c;
        end
      end
      e_mwvalid[j] = (g[j] >= 0) && s_wvalid[g[j]] && qn[g[j]] > 0 && qd[g[j]][0] == j;
    end
    for (int i = 0; i < N; i++) begin
      e_swready[i] = 1'b0;
      if (qn[i] > 0) e_swready[i] = (g[qd[i][0]] == i) && m_wready[qd[i][0]];
    end
    check("m_awvalid", m_awvalid, e_awvalid);
    check("s_awready", s_awready, e_awready);
    check("s_wready", s_wready, e_swready);
    check("m_wvalid", m_wvalid, e_mwvalid);
    for (int j = 0; j < M; j++) begin
      check($sformatf("m_wdata%0d", j), m_wdata[j], (g[j] >= 0) ? s_wdata[g[j]] : '0);
      check($sformatf("m_wstrb%0d", j), m_wstrb[j], (g[j] >= 0) ? s_wstrb[g[j]] : '0);
      check($sformatf("m_wlast%0d", j), m_wlast[j], (g[j] >= 0) ? s_wlast[g[j]] : 1'b0);
      check($sformatf("m_wsrc%0d", j), m_wsrc[j], (g[j] >= 0) ? g[j] : 0);
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      for (int j = 0; j < M; j++) begin
        if (e_mwvalid[j] && m_wready[j]) begin
          int gg;
          gg = g[j];
          if (s_wlast[gg]) begin
            for (int k = 0; k < 15; k++) qd[gg][k] = qd[gg][k+1];
            if (qn[gg] > 0) qn[gg]--;
            owner[j] = -1;
            rr[j]    = (gg + 1) % N;
          end else begin
            owner[j] = gg;
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (s_awvalid[i] && e_awready[i]) begin
          qd[i][qn[i]] = model_tgt(s_awaddr[i]);
          qn[i]++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) tick();
    @(negedge clk);
    check("rst_m_wvalid", m_wvalid, 2'b00);
    check("rst_s_wready", s_wready, 2'b00);
    check("rst_s_awready", s_awready, 2'b11);
    check("rst_m_wdata0", m_wdata[0], 32'h0);
    tick();
    rst = 1'b0;

    // Single master, 4-beat burst to slave 1.
    s_awvalid = 2'b01; s_awaddr[0] = 32'h8000_0000; s_awlen[0] = 8'd3;
    @(negedge clk);
    check("t1_awready", s_awready[0], 1'b1);
    tick();
    s_awvalid = 2'b00; s_wvalid = 2'b01; s_wstrb[0] = 4'hF;
    for (int b = 0; b < 4; b++) begin
      s_wdata[0] = 32'hA0 + b;
      s_wlast    = (b == 3) ? 2'b01 : 2'b00;
      @(negedge clk);
      check("t1_m_wvalid", m_wvalid, 2'b10);
      check("t1_m_wsrc1", m_wsrc[1], 1'b0);
      check("t1_m_wdata1", m_wdata[1], 32'hA0 + b);
      tick();
    end
    s_wlast = 2'b00;
    @(negedge clk);
    check("t1_empty_wready", s_wready[0], 1'b0);
    check("t1_empty_wvalid", m_wvalid, 2'b00);
    tick();
    s_wvalid = 2'b00;

    // Both masters to slave 0, 2-beat bursts, no interleave.
    s_awaddr[0] = 32'h0; s_awaddr[1] = 32'h0; s_awlen[0] = 8'd1; s_awlen[1] = 8'd1;
    s_awvalid = 2'b11;
    tick();
    s_awvalid = 2'b00; s_wvalid = 2'b11; s_wdata[0] = 32'h1000; s_wdata[1] = 32'h2000;
    @(negedge clk);
    check("t2a_src", m_wsrc[0], 1'b0);
    check("t2a_rdy", s_wready, 2'b01);
    tick();
    s_wdata[0] = 32'h1001; s_wlast = 2'b01;
    @(negedge clk);
    check("t2b_src", m_wsrc[0], 1'b0);
    check("t2b_last", m_wlast[0], 1'b1);
    tick();
    s_wvalid = 2'b10; s_wlast = 2'b00;
    @(negedge clk);
    check("t2c_src", m_wsrc[0], 1'b1);
    check("t2c_rdy", s_wready, 2'b10);
    tick();
    s_wdata[1] = 32'h2001; s_wlast = 2'b10;
    @(negedge clk);
    check("t2d_src", m_wsrc[0], 1'b1);
    check("t2d_data", m_wdata[0], 32'h2001);
    tick();
    s_wvalid = 2'b00; s_awlen[0] = 8'd0; s_awlen[1] = 8'd0; s_awvalid = 2'b11;
    tick();
    s_awvalid = 2'b00; s_wvalid = 2'b11; s_wlast = 2'b11;
    @(negedge clk);
    check("t2e_rr_src", m_wsrc[0], 1'b0);
    tick();
    s_wvalid = 2'b10;
    @(negedge clk);
    check("t2f_src", m_wsrc[0], 1'b1);
    tick();
    s_wvalid = 2'b00; s_wlast = 2'b00;

    // Fill master 0's FIFO, then free one slot.
    s_awaddr[0] = 32'h0; s_awlen[0] = 8'd0; s_awvalid = 2'b01;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t3_accept", s_awready[0], 1'b1);
      tick();
    end
    @(negedge clk);
    check("t3_full_ready", s_awready[0], 1'b0);
    check("t3_full_valid", m_awvalid[0], 1'b0);
    tick();
    s_wvalid = 2'b01; s_wlast = 2'b01;
    @(negedge clk);
    check("t3_nobypass", s_awready[0], 1'b0);
    check("t3_pop_rdy", s_wready[0], 1'b1);
    tick();
    s_wvalid = 2'b00;
    @(negedge clk);
    check("t3_freed", s_awready[0], 1'b1);
    tick();
    s_awvalid = 2'b00; s_wvalid = 2'b01;
    repeat (4) tick();
    s_wvalid = 2'b00; s_wlast = 2'b00;

    // W valid ahead of its AW.
    s_wvalid = 2'b10; s_wdata[1] = 32'h4444; s_wlast = 2'b10;
    repeat (3) begin
      @(negedge clk);
      check("t4_stall", s_wready[1], 1'b0);
      tick();
    end
    s_awvalid = 2'b10; s_awaddr[1] = 32'h8000_0000; s_awlen[1] = 8'd0;
    @(negedge clk);
    check("t4_aw_cycle", s_wready[1], 1'b0);
    tick();
    s_awvalid = 2'b00;
    @(negedge clk);
    check("t4_go_rdy", s_wready[1], 1'b1);
    check("t4_go_vld", m_wvalid[1], 1'b1);
    tick();
    s_wvalid = 2'b00; s_wlast = 2'b00;

    // Parallel streams, then reset mid-burst.
    s_awaddr[0] = 32'h0; s_awaddr[1] = 32'h8000_0000; s_awlen[0] = 8'd2; s_awlen[1] = 8'd2;
    s_awvalid = 2'b11;
    tick();
    s_awvalid = 2'b00; s_wvalid = 2'b11;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      check("t5_par_vld", m_wvalid, 2'b11);
      check("t5_par_rdy", s_wready, 2'b11);
      tick();
    end
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_vld", m_wvalid, 2'b00);
    check("t5_rst_rdy", s_wready, 2'b00);
    check("t5_rst_awrdy", s_awready, 2'b11);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t5_after_rdy", s_wready, 2'b00);
    check("t5_after_vld", m_wvalid, 2'b00);
    tick();
    s_wvalid = 2'b00;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) begin
        s_awvalid[i] = ($urandom_range(0, 99) < 30);
        s_awaddr[i]  = $urandom;
        s_awlen[i]   = 8'($urandom_range(0, 3));
        m_awready[i] = ($urandom_range(0, 99) < 80);
        s_wvalid[i]  = ($urandom_range(0, 99) < 60);
        s_wdata[i]   = $urandom;
        s_wstrb[i]   = 4'($urandom);
        s_wlast[i]   = ($urandom_range(0, 99) < 30);
      end
      for (int j = 0; j < M; j++) m_wready[j] = ($urandom_range(0, 99) < 70);
      tick();
    end
    rst = 1'b0;
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
